// File: rtl/ysyx_24090012_pkg.sv
// Shared constants, exception codes and FSM state type for the instruction fetch unit.
package ysyx_24090012_pkg;

  // PC loaded on reset
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  // addi x0,x0,0 delivered in place of a faulting fetch
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Exception code carried next to every delivered instruction
  typedef logic [1:0] exc_t;
  localparam exc_t EXC_NONE     = 2'b00;
  localparam exc_t EXC_AFAULT   = 2'b01;
  localparam exc_t EXC_MISALIGN = 2'b10;

  // Fetch FSM: issue request, wait for data, present to decode
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  // A fetch address is legal only on a 4-byte boundary
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24090012_ifu_if.sv
// Bus bundle around the fetch unit: redirect input, instruction-memory
// request/response channel and the {pc, inst, exc} stream toward decode.
interface ysyx_24090012_ifu_if;
  import ysyx_24090012_pkg::*;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  exc_t        out_exc;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_pc, out_inst, out_exc
  );

  // Memory / decode / commit side
  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_pc, out_inst, out_exc
  );

endinterface

// File: rtl/ysyx_24090012_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one memory read in
// flight and hands each fetched word to decode over valid/ready. Redirects
// from commit override pc+4; a read already in flight is then dropped.
module ysyx_24090012_ifu
  import ysyx_24090012_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  ysyx_24090012_ifu_if.master bus
);

  ifu_state_e  state;
  ifu_state_e  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        drop;
  logic        drop_next;
  logic [31:0] hold_pc;
  logic [31:0] hold_pc_next;
  logic [31:0] hold_inst;
  logic [31:0] hold_inst_next;
  exc_t        hold_exc;
  exc_t        hold_exc_next;
  logic        req_fire;

  // Request/output valids come from state only, forced low while reset is held
  always_comb begin
    bus.imem_req_valid = 1'b0;
    bus.out_valid      = 1'b0;
    if (rst_n) begin
      bus.imem_req_valid = (state == S_REQ) && !pc_misaligned(pc);
      bus.out_valid      = (state == S_OUT);
    end else begin
      bus.imem_req_valid = 1'b0;
      bus.out_valid      = 1'b0;
    end
  end

  assign req_fire          = bus.imem_req_valid & bus.imem_req_ready;
  assign bus.imem_req_addr = pc;
  assign bus.out_pc        = hold_pc;
  assign bus.out_inst      = hold_inst;
  assign bus.out_exc       = hold_exc;

  // Next-state, drop flag, output holding register and PC update
  always_comb begin
    state_next     = state;
    drop_next      = drop;
    hold_pc_next   = hold_pc;
    hold_inst_next = hold_inst;
    hold_exc_next  = hold_exc;
    case (state)
      S_REQ: begin
        if (bus.redirect_valid) begin
          // A request accepted together with a redirect is for the old PC
          if (req_fire) begin
            state_next = S_WAIT;
            drop_next  = 1'b1;
          end else begin
            state_next = S_REQ;
          end
        end else if (pc_misaligned(pc)) begin
          // Misaligned PC never reaches memory; report it straight away
          state_next     = S_OUT;
          hold_pc_next   = pc;
          hold_inst_next = NOP_INST;
          hold_exc_next  = EXC_MISALIGN;
        end else if (req_fire) begin
          state_next = S_WAIT;
          drop_next  = 1'b0;
        end else begin
          state_next = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop || bus.redirect_valid) begin
            state_next = S_REQ;
            drop_next  = 1'b0;
          end else begin
            state_next     = S_OUT;
            hold_pc_next   = pc;
            hold_inst_next = bus.imem_rsp_err ? NOP_INST : bus.imem_rsp_data;
            hold_exc_next  = bus.imem_rsp_err ? EXC_AFAULT : EXC_NONE;
          end
        end else if (bus.redirect_valid) begin
          drop_next = 1'b1;
        end else begin
          drop_next = drop;
        end
      end
      S_OUT: begin
        if (bus.redirect_valid || bus.out_ready) begin
          state_next = S_REQ;
        end else begin
          state_next = S_OUT;
        end
      end
      default: begin
        state_next = S_REQ;
        drop_next  = 1'b0;
      end
    endcase

    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc;
    end else if ((state == S_OUT) && bus.out_ready) begin
      pc_next = pc + 32'd4;
    end else begin
      pc_next = pc;
    end
  end

  // State, PC, drop flag and output holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      hold_pc   <= 32'h0000_0000;
      hold_inst <= 32'h0000_0000;
      hold_exc  <= EXC_NONE;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      drop      <= drop_next;
      hold_pc   <= hold_pc_next;
      hold_inst <= hold_inst_next;
      hold_exc  <= hold_exc_next;
    end
  end

endmodule

// File: tb/tb_ysyx_24090012_ifu.sv
// Bench for the fetch unit: directed scenarios followed by a randomized run
// against a transaction-level model (next delivered PC, memory contents).
module tb_ysyx_24090012_ifu;
  import ysyx_24090012_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  ysyx_24090012_ifu_if bus();

  ysyx_24090012_ifu u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state
  logic [31:0] exp_pc;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          delivered;
  logic        prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  logic [1:0]  prev_exc;

  // Memory contents as a function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
  endfunction

  // Addresses that fault
  function automatic logic mem_err(input logic [31:0] a);
    return a[6:2] == 5'd7;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    bus.out_ready      = 1'b0;
  endtask

  // Expected contents of an instruction delivered for PC p
  task automatic check_delivery(input logic [31:0] p);
    check("rnd_pc", bus.out_pc, p);
    if (p[1:0] != 2'b00) begin
      check("rnd_inst_mis", bus.out_inst, NOP_INST);
      check("rnd_exc_mis", 32'(bus.out_exc), 32'd2);
    end else if (mem_err(p)) begin
      check("rnd_inst_err", bus.out_inst, NOP_INST);
      check("rnd_exc_err", 32'(bus.out_exc), 32'd1);
    end else begin
      check("rnd_inst", bus.out_inst, mem_word(p));
      check("rnd_exc", 32'(bus.out_exc), 32'd0);
    end
  endtask

  // One randomized cycle: drive inputs, then score what happens at the next edge
  task automatic rand_cycle();
    logic        was_pend;
    logic        do_rsp;
    logic [31:0] tgt;
    int          sel;
    was_pend = pend;
    do_rsp   = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) do_rsp = 1'b1;
      else pend_cnt--;
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    bus.imem_rsp_err   = 1'($urandom_range(0, 1));
    if (do_rsp) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_addr);
      bus.imem_rsp_err   = mem_err(pend_addr);
      pend = 1'b0;
    end else if (!was_pend && ($urandom_range(0, 7) == 0)) begin
      bus.imem_rsp_valid = 1'b1;
    end
    bus.imem_req_ready = 1'($urandom_range(0, 1));
    bus.out_ready      = 1'($urandom_range(0, 1));
    bus.redirect_valid = ($urandom_range(0, 15) == 0);
    sel = $urandom_range(0, 9);
    tgt = $urandom;
    if (sel == 0)      tgt = {16'h8000, tgt[15:2], 2'b10};
    else if (sel == 1) tgt = 32'hFFFF_FFF8;
    else               tgt = {16'h8000, tgt[15:2], 2'b00};
    bus.redirect_pc = tgt;
    #1;
    if (prev_hold) begin
      check("rnd_hold_valid", 32'(bus.out_valid), 32'd1);
      check("rnd_hold_pc", bus.out_pc, prev_pc);
      check("rnd_hold_inst", bus.out_inst, prev_inst);
      check("rnd_hold_exc", 32'(bus.out_exc), 32'(prev_exc));
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("rnd_one_outstanding", 32'(pend), 32'd0);
      check("rnd_req_aligned", 32'(bus.imem_req_addr[1:0]), 32'd0);
      pend      = 1'b1;
      pend_addr = bus.imem_req_addr;
      pend_cnt  = $urandom_range(0, 3);
    end
    prev_hold = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
    prev_pc   = bus.out_pc;
    prev_inst = bus.out_inst;
    prev_exc  = bus.out_exc;
    if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      check_delivery(exp_pc);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (bus.redirect_valid) exp_pc = bus.redirect_pc;
    tick();
  endtask

  // Safety net against a hung run
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Directed scenarios, then randomized run
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_exc", 32'(bus.out_exc), 32'd0);

    // First fetch with 1-cycle response
    rst_n = 1'b1;
    #1;
    check("f1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("f1_req_addr", bus.imem_req_addr, 32'h8000_0000);
    bus.imem_req_ready = 1'b1;
    tick();
    check("f1_wait_no_req", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0010_0093;
    tick();
    bus.imem_rsp_valid = 1'b0;
    check("f1_out_valid", 32'(bus.out_valid), 32'd1);
    check("f1_out_pc", bus.out_pc, 32'h8000_0000);
    check("f1_out_inst", bus.out_inst, 32'h0010_0093);
    check("f1_out_exc", 32'(bus.out_exc), 32'd0);

    // Back-pressure from decode holds the output
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_pc", bus.out_pc, 32'h8000_0000);
      check("bp_out_inst", bus.out_inst, 32'h0010_0093);
      check("bp_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_next_req", 32'(bus.imem_req_valid), 32'd1);
    check("bp_next_addr", bus.imem_req_addr, 32'h8000_0004);

    // Redirect while waiting: late response dropped
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    check("rw_no_out", 32'(bus.out_valid), 32'd0);
    tick();
    check("rw_no_out2", 32'(bus.out_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    check("rw_dropped", 32'(bus.out_valid), 32'd0);
    check("rw_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("rw_req_addr", bus.imem_req_addr, 32'h8000_0100);

    // Redirect in the same cycle as the output handshake
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0020_0113;
    tick();
    bus.imem_rsp_valid = 1'b0;
    check("ro_out_pc", bus.out_pc, 32'h8000_0100);
    check("ro_out_inst", bus.out_inst, 32'h0020_0113);
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    tick();
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    check("ro_out_gone", 32'(bus.out_valid), 32'd0);
    check("ro_req_addr", bus.imem_req_addr, 32'h8000_0200);

    // Access fault, then misaligned redirect
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err   = 1'b1;
    bus.imem_rsp_data  = 32'h1234_5678;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    check("af_out_valid", 32'(bus.out_valid), 32'd1);
    check("af_out_exc", 32'(bus.out_exc), 32'd1);
    check("af_out_inst", bus.out_inst, 32'h0000_0013);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0002;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    #1;
    check("mis_no_req", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.imem_req_ready = 1'b0;
    check("mis_out_valid", 32'(bus.out_valid), 32'd1);
    check("mis_out_exc", 32'(bus.out_exc), 32'd2);
    check("mis_out_pc", bus.out_pc, 32'h8000_0002);
    check("mis_out_inst", bus.out_inst, 32'h0000_0013);

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    check("wr_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0073;
    tick();
    bus.imem_rsp_valid = 1'b0;
    check("wr_out_pc", bus.out_pc, 32'hFFFF_FFFC);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("wr_next_addr", bus.imem_req_addr, 32'h0000_0000);
    check("wr_next_valid", 32'(bus.imem_req_valid), 32'd1);

    // Reset in the middle of a read
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_req_low", 32'(bus.imem_req_valid), 32'd0);
    tick();
    check("mr_req_low2", 32'(bus.imem_req_valid), 32'd0);
    check("mr_out_low", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBADC_0DE5;
    #1;
    check("mr_req_after", 32'(bus.imem_req_valid), 32'd1);
    check("mr_addr_after", bus.imem_req_addr, 32'h8000_0000);
    tick();
    bus.imem_rsp_valid = 1'b0;
    check("mr_rsp_ignored", 32'(bus.out_valid), 32'd0);
    check("mr_still_req", 32'(bus.imem_req_valid), 32'd1);

    // Randomized run against the model
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n     = 1'b1;
    exp_pc    = RESET_PC;
    pend      = 1'b0;
    pend_addr = 32'h0;
    pend_cnt  = 0;
    delivered = 0;
    prev_hold = 1'b0;
    prev_pc   = 32'h0;
    prev_inst = 32'h0;
    prev_exc  = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
    end
    check("rnd_liveness", 32'(delivered >= 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
